// File: rtl/spi_controller.sv
// spi_controller: write-only SPI mode-0 initiator.
//
// Takes register-write requests (4-bit address, 8-bit data) over a
// valid/ready handshake and sends each one as a single 16-bit frame,
// MSB first: {1'b1, 3'b000, addr[3:0], data[7:0]}.
//
// Optional feature macro: SPI_CTRL_ADDR_CHECK_EN
//   When defined, a request with req_addr > 4 is accepted but not sent.
//   One cycle after acceptance, err and done pulse together.
//   When undefined, every address is sent unchanged and err is tied 0.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   write request present
//   req_ready  out  high only in IDLE
//   req_addr   in   [3:0] register address, sampled at acceptance
//   req_data   in   [7:0] register value, sampled at acceptance
//   busy       out  high from the cycle after acceptance until done
//   done       out  one-cycle pulse when a request completes
//   err        out  one-cycle pulse on address rejection
//   SCLK       out  SPI clock, idle low
//   nCS        out  chip select, active low, idle high
//   COPI       out  serial data; changes only while SCLK is low
//   state_dbg  out  [2:0] current FSM state (IDLE=0, SETUP=1, HIGH=2,
//                   LOW=3, HOLD=4, GAP=5, REJECT=6)
//
// Handshake: a request is accepted on a clk edge where
// req_valid && req_ready. req_valid is ignored outside IDLE. req_addr and
// req_data may change freely once the request is accepted.
//
// Timing, in clk cycles counted from the acceptance edge:
//   - nCS is low for 33*HALF_PERIOD cycles. That is SETUP, 16 HIGH,
//     15 LOW and HOLD, each lasting HALF_PERIOD cycles.
//   - done is asserted at cycle 1 + 33*HALF_PERIOD + GAP_CYCLES.
// HALF_PERIOD must be at least 4 so that each SCLK level survives the
// peripheral's 3-flop synchroniser.
module spi_controller #(
  parameter int HALF_PERIOD = 4,
  parameter int GAP_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       SCLK,
  output logic       nCS,
  output logic       COPI,
  output logic [2:0] state_dbg
);

  localparam int MAX_CNT = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_CNT) + 1;
  localparam logic [CW-1:0] HP_LAST  = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_HIGH   = 3'd2,
    S_LOW    = 3'd3,
    S_HOLD   = 3'd4,
    S_GAP    = 3'd5,
    S_REJECT = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;    // cycles spent in the current state
  logic [3:0]    bit_q;    // index of the bit currently on COPI
  logic [15:0]   shift_q;  // COPI is always shift_q[15]

  logic sclk_d, ncs_d, busy_d, ready_d, done_d;
  logic sclk_q, ncs_q, busy_q, ready_q, done_q;

  // ---------------------------------------------------------------------
  // Process 1: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------
  // Process 2: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
`ifdef SPI_CTRL_ADDR_CHECK_EN
          state_d = (req_addr > 4'd4) ? S_REJECT : S_SETUP;
`else
          state_d = S_SETUP;
`endif
        end
      end
      S_SETUP:  if (cnt_q == HP_LAST) state_d = S_HIGH;
      S_HIGH:   if (cnt_q == HP_LAST) state_d = (bit_q == 4'd0) ? S_HOLD : S_LOW;
      S_LOW:    if (cnt_q == HP_LAST) state_d = S_HIGH;
      S_HOLD:   if (cnt_q == HP_LAST) state_d = S_GAP;
      S_GAP:    if (cnt_q == GAP_LAST) state_d = S_IDLE;
      S_REJECT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Process 3: output logic
  // Outputs are computed from the state being entered and then
  // registered. This makes every pin a flop and removes any
  // combinational path from req_* to the pins.
  // ---------------------------------------------------------------------
  always_comb begin
    sclk_d  = (state_d == S_HIGH);
    ncs_d   = !((state_d == S_SETUP) || (state_d == S_HIGH) ||
                (state_d == S_LOW)   || (state_d == S_HOLD));
    busy_d  = (state_d == S_SETUP) || (state_d == S_HIGH) || (state_d == S_LOW) ||
              (state_d == S_HOLD)  || (state_d == S_GAP);
    ready_d = (state_d == S_IDLE);
    // The done pulse lands in the first IDLE cycle after GAP, which is
    // also the cycle in which busy falls.
    done_d  = ((state_q == S_GAP) && (state_d == S_IDLE)) || (state_d == S_REJECT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q  <= 1'b0;
      ncs_q   <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      sclk_q  <= sclk_d;
      ncs_q   <= ncs_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // Datapath: phase counter, bit counter and shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      bit_q   <= 4'd0;
      shift_q <= 16'h0000;
    end else begin
      // The phase counter restarts on every state change. It never
      // exceeds the longest hold, so it cannot wrap.
      if ((state_d != state_q) || (state_q == S_IDLE)) cnt_q <= '0;
      else                                             cnt_q <= cnt_q + CW'(1);

      if ((state_q == S_IDLE) && (state_d == S_SETUP)) begin
        shift_q <= {1'b1, 3'b000, req_addr, req_data};
        bit_q   <= 4'd15;
      end else if ((state_q == S_HIGH) && (state_d == S_LOW)) begin
        // SCLK falls on this same edge, so COPI only moves while SCLK is low.
        shift_q <= {shift_q[14:0], 1'b0};
        bit_q   <= bit_q - 4'd1;
      end else if (state_d == S_GAP) begin
        shift_q <= 16'h0000;  // COPI returns to 0 while nCS is high
      end
    end
  end

`ifdef SPI_CTRL_ADDR_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= (state_d == S_REJECT);
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign SCLK      = sclk_q;
  assign nCS       = ncs_q;
  assign COPI      = shift_q[15];
  assign busy      = busy_q;
  assign req_ready = ready_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller.
//
// Instance A uses the default timing (HALF_PERIOD=4, GAP_CYCLES=8).
// Instance B uses HALF_PERIOD=6, GAP_CYCLES=4.
//
// For each request the bench records:
//   - the frame sampled on SCLK rises,
//   - the number of SCLK rises,
//   - the nCS-low cycle count,
//   - the shortest and longest SCLK level runs while nCS is low,
//   - the accept-to-done latency.
// Expected values are hand-computed constants.
module tb_spi_controller;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  // Instance A (default timing).
  logic       valid_a = 1'b0;
  logic [3:0] addr_a  = 4'h0;
  logic [7:0] data_a  = 8'h00;
  logic       rdy_a, busy_a, done_a, err_a, sclk_a, ncs_a, copi_a;
  logic [2:0] st_a;

  // Instance B (HALF_PERIOD=6, GAP_CYCLES=4).
  logic       valid_b = 1'b0;
  logic [3:0] addr_b  = 4'h0;
  logic [7:0] data_b  = 8'h00;
  logic       rdy_b, busy_b, done_b, err_b, sclk_b, ncs_b, copi_b;
  logic [2:0] st_b;

  int n_checks = 0;
  int n_errors = 0;

  // Results of the most recent xfer call.
  logic [15:0] r_frame;
  int r_rises, r_done, r_ncs_low, r_min, r_max, r_err, r_busy1, r_rdy1, r_gap;

  // Length of the most recent nCS-high stretch on instance A.
  int hi_run_a   = 0;
  int last_gap_a = 0;

  spi_controller u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(valid_a), .req_ready(rdy_a),
    .req_addr(addr_a), .req_data(data_a), .busy(busy_a), .done(done_a),
    .err(err_a), .SCLK(sclk_a), .nCS(ncs_a), .COPI(copi_a), .state_dbg(st_a)
  );

  spi_controller #(.HALF_PERIOD(6), .GAP_CYCLES(4)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(valid_b), .req_ready(rdy_b),
    .req_addr(addr_b), .req_data(data_b), .busy(busy_b), .done(done_b),
    .err(err_b), .SCLK(sclk_b), .nCS(ncs_b), .COPI(copi_b), .state_dbg(st_b)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk) begin
    if (ncs_a) begin
      hi_run_a <= hi_run_a + 1;
    end else begin
      if (hi_run_a != 0) last_gap_a <= hi_run_a;
      hi_run_a <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic rec_run(input int r);
    if (r < r_min) r_min = r;
    if (r > r_max) r_max = r;
  endtask

  // Issue one request and follow it to its done pulse. The task is entered
  // and left on a falling clk edge. When hold is set, req_valid stays high
  // (with junk addr/data) after acceptance.
  task automatic xfer(input bit use_b, input logic [3:0] addr, input logic [7:0] data,
                      input bit hold);
    int   wait_n;
    int   run;
    logic sc, nc, co, prev_sc, lvl;
    r_frame = 16'h0; r_rises = 0; r_done = -1; r_ncs_low = 0;
    r_min = 1000; r_max = 0; r_err = 0; r_busy1 = 0; r_rdy1 = 1; r_gap = 0;
    if (use_b) begin valid_b = 1'b1; addr_b = addr; data_b = data; end
    else       begin valid_a = 1'b1; addr_a = addr; data_a = data; end
    wait_n = 0;
    while (!(use_b ? rdy_b : rdy_a) && wait_n < 400) begin
      @(negedge clk);
      wait_n++;
    end
    check("ready_wait", 32'(wait_n < 400), 32'd1);
    @(posedge clk);  // acceptance edge
    prev_sc = 1'b0; lvl = 1'b0; run = 0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (n == 1) begin
        if (use_b) begin
          if (!hold) valid_b = 1'b0;
          addr_b = 4'($urandom_range(15, 0)); data_b = 8'($urandom_range(255, 0));
        end else begin
          if (!hold) valid_a = 1'b0;
          addr_a = 4'($urandom_range(15, 0)); data_a = 8'($urandom_range(255, 0));
        end
        r_busy1 = int'(use_b ? busy_b : busy_a);
        r_rdy1  = int'(use_b ? rdy_b : rdy_a);
      end
      if (n == 3) r_gap = last_gap_a;
      sc = use_b ? sclk_b : sclk_a;
      nc = use_b ? ncs_b : ncs_a;
      co = use_b ? copi_b : copi_a;
      if (!nc) begin
        r_ncs_low++;
        if (sc && !prev_sc) begin
          r_frame = {r_frame[14:0], co};
          r_rises++;
        end
        if (run > 0 && sc == lvl) run++;
        else begin
          if (run > 0) rec_run(run);
          lvl = sc;
          run = 1;
        end
      end else if (run > 0) begin
        rec_run(run);
        run = 0;
      end
      prev_sc = sc;
      r_err += int'(use_b ? err_b : err_a);
      if (use_b ? done_b : done_a) begin
        r_done = n;
        break;
      end
    end
  endtask

  initial begin
    int   rises;
    logic prev;

    // Reset.
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", rdy_a, 1'b1);
    check("rst_sclk",  sclk_a, 1'b0);
    check("rst_ncs",   ncs_a, 1'b1);
    check("rst_copi",  copi_a, 1'b0);
    check("rst_busy",  busy_a, 1'b0);
    check("rst_done",  done_a, 1'b0);
    check("rst_err",   err_a, 1'b0);
    check("rst_state", st_a, 3'd0);
    check("rst_b_ready", rdy_b, 1'b1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame: addr 0, data 0xA5.
    xfer(1'b0, 4'h0, 8'hA5, 1'b0);
    check("a5_frame",   r_frame, 16'h80A5);
    check("a5_rises",   r_rises, 16);
    check("a5_ncs_low", r_ncs_low, 132);
    check("a5_done_at", r_done, 141);
    check("a5_run_min", r_min, 4);
    check("a5_run_max", r_max, 4);
    check("a5_busy1",   r_busy1, 1);
    check("a5_ready1",  r_rdy1, 0);
    check("a5_err",     r_err, 0);
    check("a5_idle",    st_a, 3'd0);
    repeat (3) @(negedge clk);

    // Five back-to-back requests with req_valid held high.
    for (int i = 0; i < 5; i++) begin
      logic [7:0]  d;
      logic [15:0] f;
      d = 8'(8'h11 * (i + 1));
      f = {1'b1, 3'b000, 4'(i), d};
      xfer(1'b0, 4'(i), d, i < 4);
      check($sformatf("b2b%0d_frame", i), r_frame, f);
      check($sformatf("b2b%0d_done_at", i), r_done, 141);
      if (i > 0) check($sformatf("b2b%0d_gap_ge8", i), 32'(r_gap >= 8), 32'd1);
    end
    repeat (3) @(negedge clk);

    // Reset asserted at the 7th SCLK rise of frame 0x8696.
    valid_a = 1'b1; addr_a = 4'h6; data_a = 8'h96;
    @(posedge clk);
    @(negedge clk);
    valid_a = 1'b0;
    rises = 0; prev = 1'b0;
    for (int n = 0; n < 200 && rises < 7; n++) begin
      @(negedge clk);
      if (sclk_a && !prev) rises++;
      prev = sclk_a;
    end
    check("mid_rises",    rises, 7);
    check("mid_copi_pre", copi_a, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_sclk",  sclk_a, 1'b0);
    check("mid_ncs",   ncs_a, 1'b1);
    check("mid_copi",  copi_a, 1'b0);
    check("mid_busy",  busy_a, 1'b0);
    check("mid_state", st_a, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(1'b0, 4'h3, 8'h3C, 1'b0);
    check("post_rst_frame",   r_frame, 16'h833C);
    check("post_rst_done_at", r_done, 141);
    repeat (3) @(negedge clk);

    // Instance B: HALF_PERIOD=6, GAP_CYCLES=4.
    xfer(1'b1, 4'h2, 8'hC3, 1'b0);
    check("hp6_frame",   r_frame, 16'h82C3);
    check("hp6_rises",   r_rises, 16);
    check("hp6_ncs_low", r_ncs_low, 198);
    check("hp6_done_at", r_done, 203);
    check("hp6_run_min", r_min, 6);
    check("hp6_run_max", r_max, 6);
    repeat (3) @(negedge clk);

    // Address 9.
    xfer(1'b0, 4'h9, 8'h5A, 1'b0);
`ifdef SPI_CTRL_ADDR_CHECK_EN
    check("rej_done_at", r_done, 1);
    check("rej_err",     r_err, 1);
    check("rej_ncs_low", r_ncs_low, 0);
    check("rej_busy1",   r_busy1, 0);
`else
    check("a9_frame",   r_frame, 16'h895A);
    check("a9_done_at", r_done, 141);
    check("a9_err",     r_err, 0);
`endif
    repeat (2) @(negedge clk);
    check("end_idle", st_a, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
